// File: rtl/stall_result_sink_if.sv
// Handshake bundle between the arithmetic pipeline/consumer and stall_result_sink.
// STALL_RESULT_SINK_STATS_EN adds the stall_cycles/results_total statistics outputs.
interface stall_result_sink_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic [DATA_W-1:0] res_in;
  logic              stall;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  count;

`ifdef STALL_RESULT_SINK_STATS_EN
  logic [15:0]       stall_cycles;
  logic [15:0]       results_total;

  modport master (
    input  in_valid, res_in, out_ready,
    output stall, out_valid, out_data, count, stall_cycles, results_total
  );
  modport slave (
    output in_valid, res_in, out_ready,
    input  stall, out_valid, out_data, count, stall_cycles, results_total
  );
`else
  modport master (
    input  in_valid, res_in, out_ready,
    output stall, out_valid, out_data, count
  );
  modport slave (
    output in_valid, res_in, out_ready,
    input  stall, out_valid, out_data, count
  );
`endif
endinterface

// File: rtl/stall_result_sink.sv
// Result sink for a stall-gated pipeline: tracks valid slots, captures results into a
// show-ahead FIFO and raises stall when full. STALL_RESULT_SINK_STATS_EN enables stats.
module stall_result_sink #(
  parameter int DATA_W = 16,
  parameter int LAT    = 3,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  stall_result_sink_if.master  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [LAT-1:0]    vpipe_q, vpipe_d, vpipe_shift;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic stall;
  logic push;
  logic pop;

  assign stall = (count_q == CNT_W'(DEPTH));
  assign push  = vpipe_q[LAT-1] & ~stall;
  assign pop   = (count_q != '0) & bus.out_ready;

  generate
    if (LAT == 1) begin : g_vpipe_single
      assign vpipe_shift = bus.in_valid;
    end else begin : g_vpipe_multi
      assign vpipe_shift = {vpipe_q[LAT-2:0], bus.in_valid};
    end
  endgenerate

  always_comb begin
    vpipe_d    = vpipe_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_data_d = out_data_q;

    if (!stall) begin
      vpipe_d = vpipe_shift;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Head register: forward res_in when this edge writes the slot that becomes the head.
    if (count_d == '0) begin
      out_data_d = '0;
    end else if (push && (wr_ptr_q == rd_ptr_d)) begin
      out_data_d = bus.res_in;
    end else begin
      out_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      out_data_q <= '0;
    end else begin
      vpipe_q    <= vpipe_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.res_in;
    end
  end

  assign bus.stall     = stall;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = out_data_q;
  assign bus.count     = count_q;

`ifdef STALL_RESULT_SINK_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] results_total_q, results_total_d;

  always_comb begin
    stall_cycles_d  = stall_cycles_q;
    results_total_d = results_total_q;
    if (stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
    if (push) begin
      results_total_d = results_total_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q  <= '0;
      results_total_q <= '0;
    end else begin
      stall_cycles_q  <= stall_cycles_d;
      results_total_q <= results_total_d;
    end
  end

  assign bus.stall_cycles  = stall_cycles_q;
  assign bus.results_total = results_total_q;
`endif
endmodule

// File: tb/tb_stall_result_sink.sv
// Directed bench for stall_result_sink with a stall-gated 3-stage data pipeline model.
module tb_stall_result_sink;
  localparam int DATA_W = 16;
  localparam int LAT    = 3;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] pipe_q [LAT];
  logic [DATA_W-1:0] exp_q [$];
  int n_checks = 0;
  int n_fails  = 0;
  int pop_cnt  = 0;

  always #5 clk = ~clk;

  stall_result_sink_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  stall_result_sink #(.DATA_W(DATA_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Arithmetic pipeline stand-in: data moves only when stall is low.
  always @(posedge clk) begin
    if (!bus.stall) begin
      pipe_q[0] <= din;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign bus.res_in = pipe_q[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a sample and hold it until an edge with stall low accepts it.
  task automatic issue(input logic [DATA_W-1:0] v);
    bus.in_valid = 1'b1;
    din = v;
    for (int n = 0; bus.stall && n < 100; n++) tick();
    if (bus.stall) chk("issue_stall_timeout", 32'(bus.stall), 32'd0);
    exp_q.push_back(v);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    for (int n = 0; bus.count != 0 && n < 40; n++) tick();
    chk(tag, 32'(bus.count), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  // Popped data must match the order samples were accepted; stall must mirror full.
  always @(negedge clk) begin
    chk("stall_eq_full", 32'(bus.stall), 32'(bus.count == 3'(DEPTH)));
    if (rst && bus.out_valid && bus.out_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) chk("model_nonempty_on_pop", 32'd0, 32'd1);
      else chk("pop_order", 32'(bus.out_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int p0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Single sample: result 0x0903 visible after edge 3, popped at edge 4
    bus.out_ready = 1'b1;
    issue(16'h0903);
    tick(); tick();
    chk("single_not_yet", 32'(bus.out_valid), 32'd0);
    tick();
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_data", 32'(bus.out_data), 32'h0903);
    chk("single_count", 32'(bus.count), 32'd1);
    tick();
    chk("single_popped_count", 32'(bus.count), 32'd0);
    chk("single_popped_valid", 32'(bus.out_valid), 32'd0);
`ifdef STALL_RESULT_SINK_STATS_EN
    chk("stats_results_total", 32'(bus.results_total), 32'd1);
`endif
    bus.out_ready = 1'b0;
    tick();

    // Backpressure: 8 back-to-back samples with consumer stalled, then released
    p0 = pop_cnt;
    fork
      begin
        for (int k = 1; k <= 8; k++) issue(16'(k));
      end
      begin
        for (int n = 0; bus.count != 3'(DEPTH) && n < 20; n++) tick();
        chk("bp_full_count", 32'(bus.count), 32'd4);
        chk("bp_stall", 32'(bus.stall), 32'd1);
        tick(); tick(); tick();
        chk("bp_hold_count", 32'(bus.count), 32'd4);
        chk("bp_hold_pops", 32'(pop_cnt - p0), 32'd0);
        bus.out_ready = 1'b1;
        for (int n = 0; (pop_cnt - p0) < 8 && n < 60; n++) tick();
        chk("bp_pop_total", 32'(pop_cnt - p0), 32'd8);
      end
    join
    tick();
    chk("bp_empty", 32'(bus.count), 32'd0);
    bus.out_ready = 1'b0;
    tick();

    // Simultaneous push and pop at count 2
    issue(16'h0A01); issue(16'h0A02); issue(16'h0A03);
    tick(); tick();
    chk("pp_count_before", 32'(bus.count), 32'd2);
    chk("pp_head_before", 32'(bus.out_data), 32'h0A01);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("pp_count_after", 32'(bus.count), 32'd2);
    chk("pp_head_after", 32'(bus.out_data), 32'h0A02);
    drain("pp_drain");
    tick();

    // Full release: count 4 with a held token in the last slot
    for (int k = 1; k <= 5; k++) issue(16'hF000 | 16'(k));
    tick(); tick();
    chk("fr_full_count", 32'(bus.count), 32'd4);
    chk("fr_full_stall", 32'(bus.stall), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("fr_release_count", 32'(bus.count), 32'd3);
    chk("fr_release_stall", 32'(bus.stall), 32'd0);
    chk("fr_release_head", 32'(bus.out_data), 32'hF002);
    tick();
    chk("fr_refill_count", 32'(bus.count), 32'd4);
    chk("fr_refill_stall", 32'(bus.stall), 32'd1);
    drain("fr_drain");
    tick();

`ifdef STALL_RESULT_SINK_STATS_EN
    // Stall counter: five edges spent full
    begin
      logic [15:0] sc0;
      for (int k = 1; k <= 4; k++) issue(16'h5000 | 16'(k));
      for (int n = 0; bus.count != 3'(DEPTH) && n < 20; n++) tick();
      chk("stats_full", 32'(bus.count), 32'd4);
      sc0 = bus.stall_cycles;
      for (int n = 0; n < 5; n++) tick();
      chk("stats_stall_cycles", 32'(bus.stall_cycles - sc0), 32'd5);
      drain("stats_drain");
      tick();
    end
`endif

    // Reset mid-flight: 3 tokens in the tracker, 2 in the FIFO
    for (int k = 1; k <= 5; k++) issue(16'hB000 | 16'(k));
    chk("mr_count_before", 32'(bus.count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    chk("mr_count", 32'(bus.count), 32'd0);
    chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_out_data", 32'(bus.out_data), 32'd0);
    chk("mr_stall", 32'(bus.stall), 32'd0);
    tick();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("mr_no_stale_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.out_ready = 1'b0;
    chk("mr_final_count", 32'(bus.count), 32'd0);
    chk("model_empty_at_end", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
